// File: rtl/pulse_event_arbiter_pkg.sv
// Shared types and helpers for the pulse event arbiter.
package pulse_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  // Index width for n items, never below one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] all_ones;
    all_ones = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= all_ones) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pulse_event_arbiter_if.sv
// Requester/channel bundle of the pulse event arbiter. The master side
// drives requests and channel status; the slave side is the arbiter.
interface pulse_event_arbiter_if
  import pulse_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DROP_W = 8
) ();

  localparam int ID_W = id_w(N_REQ);

  logic              enable_i;
  logic [N_REQ-1:0]  req_i;
  logic              chan_ready_i;
  logic [N_REQ-1:0]  ovf_clr_i;
  logic              chan_pulse_o;
  logic [ID_W-1:0]   chan_id_o;
  logic [N_REQ-1:0]  pending_o;
  logic [N_REQ-1:0]  ovf_o;
  logic [DROP_W-1:0] drop_cnt_o;
  logic              busy_o;

  modport master (
    output enable_i, req_i, chan_ready_i, ovf_clr_i,
    input  chan_pulse_o, chan_id_o, pending_o, ovf_o, drop_cnt_o, busy_o
  );

  modport slave (
    input  enable_i, req_i, chan_ready_i, ovf_clr_i,
    output chan_pulse_o, chan_id_o, pending_o, ovf_o, drop_cnt_o, busy_o
  );

endinterface

// File: rtl/pulse_event_arbiter_rr_pick.sv
// Circular priority picker: first set request bit searching upward from
// i_last+1, wrapping at N_REQ.
module rr_pick
  import pulse_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_idx
);

  // Walk the N_REQ candidates in rotated order and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [ID_W-1:0] cand;
      cand = ID_W'((int'(i_last) + k) % N_REQ);
      if (!o_valid && i_req[cand]) begin
        o_valid = 1'b1;
        o_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Shares one pulse-synchronizer channel between N_REQ single-cycle event
// sources: latches events as pending bits, issues them round-robin with a
// minimum spacing, and flags/counts events lost while still pending.
module pulse_event_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 6,
  parameter int DROP_W     = 8
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  pulse_event_arbiter_if.slave arb_if
);

  localparam int ID_W  = id_w(N_REQ);
  localparam int CNT_W = id_w(GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_gap;
  logic [CNT_W-1:0]  w_gap_nxt;
  logic [ID_W-1:0]   r_last;
  logic [ID_W-1:0]   r_id;
  logic              r_pulse;
  logic [N_REQ-1:0]  r_pending;
  logic [N_REQ-1:0]  r_ovf;
  logic [DROP_W-1:0] r_drop;

  logic              w_valid;
  logic [ID_W-1:0]   w_idx;
  logic              w_grant;
  logic [N_REQ-1:0]  w_gnt_vec;
  logic [N_REQ-1:0]  w_drop_vec;
  logic [N_REQ-1:0]  w_pend_nxt;
  logic [N_REQ-1:0]  w_ovf_nxt;
  logic [DROP_W-1:0] w_drop_nxt;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req   (r_pending),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  // Issue decision and gap countdown; enable/ready only matter in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (arb_if.enable_i && arb_if.chan_ready_i && w_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = GAP;
          w_gap_nxt   = GAP_LOAD;
        end
      end
      GAP: begin
        if (r_gap == '0) w_state_nxt = IDLE;
        else             w_gap_nxt   = r_gap - CNT_W'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A request on a pending bit is a drop unless that bit is being granted
  // now, in which case the new event simply re-arms the pending bit.
  assign w_gnt_vec  = w_grant ? (N_REQ'(1) << w_idx) : '0;
  assign w_drop_vec = arb_if.req_i & r_pending & ~w_gnt_vec;
  assign w_pend_nxt = (r_pending & ~w_gnt_vec) | arb_if.req_i;
  assign w_ovf_nxt  = (r_ovf & ~arb_if.ovf_clr_i) | w_drop_vec;
  assign w_drop_nxt = (|w_drop_vec) ? DROP_W'(sat_inc(32'(r_drop), DROP_W)) : r_drop;

  // State, pulse/tag and bookkeeping registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= IDLE;
      r_gap     <= '0;
      r_last    <= LAST_RST;
      r_id      <= '0;
      r_pulse   <= 1'b0;
      r_pending <= '0;
      r_ovf     <= '0;
      r_drop    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_gap     <= w_gap_nxt;
      r_pulse   <= w_grant;
      r_pending <= w_pend_nxt;
      r_ovf     <= w_ovf_nxt;
      r_drop    <= w_drop_nxt;
      if (w_grant) begin
        r_last <= w_idx;
        r_id   <= w_idx;
      end
    end
  end

  assign arb_if.chan_pulse_o = r_pulse;
  assign arb_if.chan_id_o    = r_id;
  assign arb_if.pending_o    = r_pending;
  assign arb_if.ovf_o        = r_ovf;
  assign arb_if.drop_cnt_o   = r_drop;
  assign arb_if.busy_o       = (r_state != IDLE) || (|r_pending);

endmodule

// File: doc/pulse_event_arbiter.md
Name: pulse_event_arbiter

Overview:
- Shares one clock-domain-crossing pulse channel between N_REQ single-cycle event requesters, all in one clock domain.
- Latches each request as a pending bit and issues them to the channel one at a time in round-robin order.
- Enforces a minimum spacing between issued pulses, and flags and counts events lost while the same requester was still pending.
- Sits in front of the pulse synchronizer; chan_id_o travels alongside as a tag, e.g. to a PWM or encoder domain.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- GAP_CYCLES, 6, idle clocks after each issued pulse before the next may issue (>=1); covers the synchronizer hold round-trip.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- enable_i  in  1  when low, no new pulse issues; requests still latch.
- req_i  in  N_REQ  per-requester single-cycle event strobes.
- chan_ready_i  in  1  channel can accept a pulse (synchronizer hold clear).
- chan_pulse_o  out  1  one-clock pulse into the synchronizer.
- chan_id_o  out  ID_W  index of the requester served; ID_W = max(1, clog2(N_REQ)).
- pending_o  out  N_REQ  latched, not-yet-issued events.
- ovf_o  out  N_REQ  sticky per-requester overflow flags.
- ovf_clr_i  in  N_REQ  per-bit clear of ovf_o.
- drop_cnt_o  out  DROP_W  total dropped events, saturating.
- busy_o  out  1  high when state is not IDLE or pending_o is not zero.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-GAP or during a pulse):
  - chan_pulse_o=0, chan_id_o=0, pending=0, ovf=0, drop_cnt=0.
  - State=IDLE, gap counter=0, last_grant=N_REQ-1, so the first grant searches from index 0.
- State machine: IDLE and GAP.
- IDLE, when enable_i=1, chan_ready_i=1 and pending is not zero, at the clock edge:
  - Select idx = first set pending bit searching upward, circularly, from last_grant+1.
  - Set chan_pulse_o=1, chan_id_o=idx, clear pending[idx], last_grant=idx, gap counter=GAP_CYCLES-1, go to GAP.
- In every other cycle chan_pulse_o=0. chan_id_o holds its last value.
- GAP: if the counter is 0, go to IDLE; otherwise decrement. enable_i and chan_ready_i are ignored in GAP.
- Resulting timing:
  - Issued pulses are at least GAP_CYCLES+1 clocks apart.
  - Latency from req_i sampled high to chan_pulse_o high is 2 clocks when IDLE and uncontended: edge 1 sets pending, edge 2 issues.
- Request latch, per bit i, evaluated in this order:
  - req_i[i]=1 and pending[i]=1 and i is not being granted this cycle: the event is dropped. ovf[i] sets; drop_cnt increments, saturating at all-ones. pending[i] stays 1.
  - req_i[i]=1 in the same cycle that i is granted: pending[i] stays 1. A new event, not a drop.
  - Otherwise req_i[i]=1 sets pending[i].
- Several requesters dropping in the same cycle: drop_cnt increments by 1 only. The count is a lower bound; ovf_o identifies the sources.
- ovf_clr_i[i]=1 clears ovf[i]. A simultaneous new overflow on the same bit wins (the bit stays set).
- enable_i low: pending keeps accumulating and drops still count. An in-progress GAP completes normally.
- chan_ready_i low in IDLE: stall with no pulse. Issue resumes on the first cycle it is high.
- Round-robin fairness: with all N_REQ pending continuously, each requester is served once per N_REQ issues.
- All outputs are registered except busy_o, which is combinational from registers.

Decomposition:
- Shared package (pulse_arb_pkg):
  - State enum: IDLE, GAP.
  - ID_W function.
  - Saturating-increment helper for DROP_W.
- One sub-module, rr_pick: combinational circular priority picker.
  - Inputs: request vector, last_grant.
  - Outputs: valid, idx.
  - Parameterised by N_REQ.

Test Plan:
1. Reset, then req_i=0100 for one clock with GAP_CYCLES=6 -> chan_pulse_o high 2 clocks later for one clock; chan_id_o=2; pending_o returns to 0000.
2. req_i=1111 in one clock -> four pulses with ids 0,1,2,3, spaced exactly 7 clocks; repeating the pattern gives 0,1,2,3 again.
3. req_i[1] pulsed 3 times while pending[1]=1 and chan_ready_i=0 -> ovf_o[1]=1, drop_cnt_o=3. After chan_ready_i=1, exactly one pulse with id 1. ovf_clr_i[1] then clears ovf_o[1].
4. req_i[0] asserted in the exact cycle id 0 is granted -> no drop; a second pulse with id 0 follows 7 clocks later.
5. enable_i=0 while req_i=0011 -> no pulses, busy_o=1. After enable_i=1, pulses with ids 0 then 1.
6. rstn_i low mid-GAP with pending=1010 -> all outputs 0 immediately. After release, with no new requests, no pulses.
